// File: rtl/fifo_reader_tx.sv
// Pulls bytes from a FIFO and sends them as UART-style frames on tx:
// start bit, 8 data bits LSB first, optional even parity, stop bit.
module fifo_reader_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        buf_empty,
    input  logic [7:0]  buf_out,
    output logic        rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state;
    logic [7:0] shreg;
    logic       par_bit;
    logic [7:0] bit_cnt;
    logic [2:0] bit_idx;
    logic       bit_done;

    assign bit_done = (bit_cnt == BIT_LAST);

    // Outputs are registered with the value belonging to the state being entered,
    // so tx/rd_en/busy always line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            rd_en    <= 1'b0;
            busy     <= 1'b0;
            byte_cnt <= 16'h0000;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            bit_cnt  <= 8'h00;
            bit_idx  <= 3'd0;
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (tx_en && !buf_empty) begin
                        state <= POP;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                // buf_out is valid only during this cycle, one after the pop strobe
                LOAD: begin
                    shreg   <= buf_out;
                    par_bit <= ^buf_out;
                    bit_cnt <= 8'h00;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= 8'h00;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= 8'h00;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= 8'h00;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                // Chain straight into the next pop when more data is waiting
                STOP: begin
                    if (bit_done) begin
                        bit_cnt  <= 8'h00;
                        byte_cnt <= byte_cnt + 16'd1;
                        if (tx_en && !buf_empty) begin
                            state <= POP;
                            rd_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader_tx.sv
// Bench for fifo_reader_tx: two instances (parity off / on) fed by FIFO models,
// serial output decoded against a scoreboard of pushed bytes.
module tb_fifo_reader_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en0, tx_en1;
    logic        buf_empty0 = 1'b1;
    logic        buf_empty1 = 1'b1;
    logic [7:0]  buf_out0 = 8'h00;
    logic [7:0]  buf_out1 = 8'h00;
    logic        rd_en0, rd_en1;
    logic        tx0, tx1;
    logic        busy0, busy1;
    logic [15:0] byte_cnt0, byte_cnt1;

    logic [7:0]  fifo0[$];
    logic [7:0]  fifo1[$];
    logic [7:0]  exp0[$];
    logic [7:0]  exp1[$];

    int cyc = 0;
    int rd_cnt0 = 0;
    int rd_cnt1 = 0;
    int rd_cyc0 = 0;
    int rd_cyc1 = 0;
    int underflow0 = 0;
    int underflow1 = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_reader_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en0), .buf_empty(buf_empty0),
        .buf_out(buf_out0), .rd_en(rd_en0), .tx(tx0), .busy(busy0),
        .byte_cnt(byte_cnt0)
    );

    fifo_reader_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .buf_empty(buf_empty1),
        .buf_out(buf_out1), .rd_en(rd_en1), .tx(tx1), .busy(busy1),
        .byte_cnt(byte_cnt1)
    );

    // FIFO models: data appears the cycle after a pop, empty flag is registered
    always @(posedge clk) begin
        if (rd_en0) begin
            rd_cnt0++;
            rd_cyc0 = cyc;
            if (fifo0.size() > 0) buf_out0 <= fifo0.pop_front();
            else underflow0++;
        end
        if (rd_en1) begin
            rd_cnt1++;
            rd_cyc1 = cyc;
            if (fifo1.size() > 0) buf_out1 <= fifo1.pop_front();
            else underflow1++;
        end
        buf_empty0 <= (fifo0.size() == 0);
        buf_empty1 <= (fifo1.size() == 0);
        cyc++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] b);
        if (d == 0) begin
            fifo0.push_back(b);
            exp0.push_back(b);
        end else begin
            fifo1.push_back(b);
            exp1.push_back(b);
        end
    endtask

    function automatic logic get_tx(input int d);
        return (d == 0) ? tx0 : tx1;
    endfunction

    task automatic resetDut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset tx0", tx0, 1'b1);
        checkOutput("reset busy0", busy0, 1'b0);
        checkOutput("reset byte_cnt0", byte_cnt0, 16'h0000);
        rst = 1'b0;
    endtask

    // Waits for a start bit, then checks every cycle of the frame against the
    // next scoreboard byte. Optionally drops tx_en0 or pulses rst at a frame bit.
    task automatic captureFrame(input int d, input int drop_bit, input int rst_bit,
                                output int start_cyc);
        int n;
        int sz;
        int nbits;
        logic [7:0] b;
        logic e;
        start_cyc = -1;
        n = 0;
        while (get_tx(d) !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("frame start d%0d", d), get_tx(d), 1'b0);
        if (get_tx(d) !== 1'b0) return;
        start_cyc = cyc;
        checkOutput($sformatf("busy at start d%0d", d), (d == 0) ? busy0 : busy1, 1'b1);
        sz = (d == 0) ? exp0.size() : exp1.size();
        checks++;
        assert (sz > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard d%0d: observed unexpected frame expected none", d);
        end
        if (sz == 0) return;
        b = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        nbits = (d == 0) ? 10 : 11;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) e = 1'b0;
            else if (i <= 8) e = b[i-1];
            else if (i == 9 && d == 1) e = ^b;
            else e = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (i == drop_bit && c == 0) tx_en0 = 1'b0;
                if (i == rst_bit && c == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                checkOutput($sformatf("tx d%0d byte %0h bit %0d cyc %0d", d, b, i, c), get_tx(d), e);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int st, st1, st2, st3, rd_base;
        rst = 1'b1;
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx0", tx0, 1'b1);
        checkOutput("reset rd_en0", rd_en0, 1'b0);
        checkOutput("reset busy0", busy0, 1'b0);
        checkOutput("reset byte_cnt0", byte_cnt0, 16'h0000);
        checkOutput("reset tx1", tx1, 1'b1);
        checkOutput("reset busy1", busy1, 1'b0);
        checkOutput("reset byte_cnt1", byte_cnt1, 16'h0000);
        rst = 1'b0;

        // Single byte, no parity
        tx_en0 = 1'b1;
        applyStimulus(0, 8'hA5);
        captureFrame(0, -1, -1, st);
        checkOutput("A5 rd_to_start", st - rd_cyc0, 2);
        checkOutput("A5 busy after", busy0, 1'b0);
        checkOutput("A5 tx after", tx0, 1'b1);
        checkOutput("A5 byte_cnt", byte_cnt0, 16'd1);
        checkOutput("A5 rd pulses", rd_cnt0, 1);

        // Parity instance: 0xA5 (parity 0) then 0x07 (parity 1)
        tx_en1 = 1'b1;
        applyStimulus(1, 8'hA5);
        captureFrame(1, -1, -1, st);
        checkOutput("par A5 rd_to_start", st - rd_cyc1, 2);
        checkOutput("par A5 busy after 44", busy1, 1'b0);
        applyStimulus(1, 8'h07);
        captureFrame(1, -1, -1, st);
        checkOutput("par 07 busy after 44", busy1, 1'b0);
        checkOutput("par byte_cnt", byte_cnt1, 16'd2);
        checkOutput("par rd pulses", rd_cnt1, 2);

        // Back-to-back frames
        resetDut();
        rd_base = rd_cnt0;
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(0, 8'h03);
        captureFrame(0, -1, -1, st1);
        captureFrame(0, -1, -1, st2);
        captureFrame(0, -1, -1, st3);
        checkOutput("b2b gap 1-2", st2 - st1, 10 * CPB + 2);
        checkOutput("b2b gap 2-3", st3 - st2, 10 * CPB + 2);
        checkOutput("b2b byte_cnt", byte_cnt0, 16'd3);
        checkOutput("b2b rd pulses", rd_cnt0 - rd_base, 3);
        checkOutput("b2b busy after", busy0, 1'b0);

        // tx_en dropped in data bit 3 with FIFO still holding a byte
        applyStimulus(0, 8'h3C);
        applyStimulus(0, 8'hC3);
        captureFrame(0, 4, -1, st);
        checkOutput("drop byte_cnt", byte_cnt0, 16'd4);
        checkOutput("drop busy after", busy0, 1'b0);
        rd_base = rd_cnt0;
        repeat (10) @(negedge clk);
        checkOutput("drop no rd", rd_cnt0 - rd_base, 0);
        checkOutput("drop idle busy", busy0, 1'b0);
        checkOutput("drop idle tx", tx0, 1'b1);
        tx_en0 = 1'b1;
        @(negedge clk);
        checkOutput("restart rd_en", rd_en0, 1'b1);
        captureFrame(0, -1, -1, st);
        checkOutput("restart rd_to_start", st - rd_cyc0, 2);
        checkOutput("restart byte_cnt", byte_cnt0, 16'd5);

        // Reset pulsed in data bit 3
        applyStimulus(0, 8'h5A);
        captureFrame(0, -1, 4, st);
        checkOutput("midreset tx", tx0, 1'b1);
        checkOutput("midreset busy", busy0, 1'b0);
        checkOutput("midreset byte_cnt", byte_cnt0, 16'd0);
        rd_base = rd_cnt0;
        repeat (10) @(negedge clk);
        checkOutput("midreset no rd", rd_cnt0 - rd_base, 0);
        applyStimulus(0, 8'h96);
        @(negedge clk);
        checkOutput("post-reset rd_en early", rd_en0, 1'b0);
        @(negedge clk);
        checkOutput("post-reset rd_en", rd_en0, 1'b1);
        captureFrame(0, -1, -1, st);
        checkOutput("post-reset byte_cnt", byte_cnt0, 16'd1);

        // Counter wrap
        force dut0.byte_cnt = 16'hFFFF;
        @(negedge clk);
        release dut0.byte_cnt;
        checkOutput("preload byte_cnt", byte_cnt0, 16'hFFFF);
        applyStimulus(0, 8'hFF);
        captureFrame(0, -1, -1, st);
        checkOutput("wrap byte_cnt", byte_cnt0, 16'h0000);

        checkOutput("underflow0", underflow0, 0);
        checkOutput("underflow1", underflow1, 0);
        checkOutput("scoreboard0 drained", exp0.size(), 0);
        checkOutput("scoreboard1 drained", exp1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader_tx.md
FIFO_READER_TX -- requirements
Module: fifo_reader_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_en  input  1  permit to start new frames.
REQ-006 SHALL have port buf_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port buf_out  input  8  FIFO read data, valid the cycle after a rd_en cycle.
REQ-008 SHALL have port rd_en  output  1  FIFO pop strobe, one cycle per byte.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port byte_cnt  output  16  count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-012 SHALL implement Moore FSM states IDLE, POP, LOAD, START, DATA, PARITY, STOP; all outputs registered or decoded from state only.
REQ-013 IDLE: tx=1, rd_en=0; at a clk edge with tx_en=1 and buf_empty=0, SHALL go to POP.
REQ-014 POP: rd_en=1 for exactly one cycle; SHALL go to LOAD unconditionally; buf_empty not resampled.
REQ-015 LOAD: SHALL capture buf_out into an 8-bit shift register at the closing edge, go to START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index 0..7; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: tx = XOR of the 8 captured bits (even parity), CLKS_PER_BIT cycles, then STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; at final edge byte_cnt SHALL increment by 1 and FSM SHALL go to POP if tx_en=1 and buf_empty=0, else IDLE.
REQ-020 Latency: edge sampling buf_empty=0 in IDLE = E0; rd_en high in cycle after E0; tx falls 2 cycles after rd_en rises.
REQ-021 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles of START..STOP; back-to-back frames separated by exactly 2 idle-high cycles (POP, LOAD).
REQ-022 rd_en SHALL never be asserted while the FSM samples buf_empty=1, and never twice for one frame.
REQ-023 tx_en deassertion mid-frame SHALL NOT abort the frame; only blocks the next start.
REQ-024 Bit-time counter SHALL be 8 bits, reload to 0 on each bit boundary; no bit shortened or stretched.
REQ-025 tx and buf_out SHALL have no combinational path between them.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, tx=1, rd_en=0, busy=0, byte_cnt=0, shift register=0, counters=0.
REQ-027 Reset asserted in any state (including POP/LOAD) SHALL abandon the frame; a byte already popped is dropped and not counted.
REQ-028 After rst deasserts, first possible rd_en SHALL be the cycle after the first edge that sees tx_en=1, buf_empty=0.

Verification
REQ-029 CLKS_PER_BIT=4, PARITY_EN=0, one byte 0xA5 presented -> single rd_en pulse; tx = 0, 1,0,1,0,0,1,0,1, 1 each 4 cycles (40 cycles); byte_cnt=1; busy low after.
REQ-030 PARITY_EN=1, byte 0xA5 -> parity bit 0, frame 44 cycles; byte 0x07 -> parity bit 1.
REQ-031 Three bytes 0x01,0x02,0x03 queued, tx_en=1 -> three rd_en pulses, exactly 2 tx-high cycles between stop and next start, byte_cnt=3.
REQ-032 tx_en dropped mid-DATA with FIFO non-empty -> current frame completes, no further rd_en, FSM idles; tx_en raised -> next frame starts per REQ-020.
REQ-033 rst pulsed during bit 3 of DATA -> next edge tx=1, busy=0, byte_cnt=0; no extra rd_en.
REQ-034 byte_cnt preloaded by sending 65536 frames (or forced to 0xFFFF) plus one more frame -> byte_cnt=0x0000.
